mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_array.sv | 25 ++
 rtl/mem_responder.sv | 134 +++++++++++++
 tb/tb_mem_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-stated memory responder and its storage.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH_WORDS = 64;
    localparam int DEFAULT_WAIT_CYCLES = 2;
    localparam int CNT_W               = 4;

    // Word-address width for a given depth; never narrower than one bit.
    function automatic int word_addr_width(input int depth);
        if (depth <= 2) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed single-port RAM with a registered read; contents survive reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int AW          = word_addr_width(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Read-before-write: a write cycle returns the old word, which the responder discards.
    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= r_mem[waddr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-mapped responder: latches one request, inserts wait states, then pulses ack with data/flags.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        out_of_range,
    output logic        busy
);

    localparam int             AW       = word_addr_width(DEPTH_WORDS);
    localparam bit             HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = HAS_WAIT ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_wr;
    logic [AW-1:0]      r_word;
    logic [31:0]        r_wdata;
    logic               r_misaligned;
    logic               r_out_of_range;

    logic               w_misaligned;
    logic               w_out_of_range;
    logic               w_err;
    logic               w_access;
    logic               w_we;
    logic [AW-1:0]      w_ram_addr;
    logic [31:0]        w_ram_wdata;
    logic [31:0]        w_ram_rdata;
    logic               w_in_idle;

    assign w_misaligned   = (addr[1:0] != 2'b00);
    assign w_out_of_range = (addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_err          = w_misaligned | w_out_of_range;
    assign w_in_idle      = (r_state == IDLE);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_access     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_err) begin
                        w_state_next = RESP;
                    end else if (HAS_WAIT) begin
                        w_state_next = WAIT;
                        w_cnt_next   = CNT_LOAD;
                    end else begin
                        w_state_next = RESP;
                        w_access     = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = RESP;
                    w_access     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Zero-wait accesses happen on the sampling edge, so the RAM sees the live request then.
    assign w_ram_addr  = w_in_idle ? addr[AW+1:2] : r_word;
    assign w_ram_wdata = w_in_idle ? wdata : r_wdata;
    assign w_we        = w_access & (w_in_idle ? wr : r_wr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_wr           <= 1'b0;
            r_word         <= '0;
            r_wdata        <= '0;
            r_misaligned   <= 1'b0;
            r_out_of_range <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_in_idle && req) begin
                r_wr           <= wr;
                r_word         <= addr[AW+1:2];
                r_wdata        <= wdata;
                r_misaligned   <= w_misaligned;
                r_out_of_range <= w_out_of_range;
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem_array (
        .clock (clock),
        .we    (w_we),
        .waddr (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    always_comb begin
        ack          = (r_state == RESP);
        busy         = ~w_in_idle;
        misaligned   = ack & r_misaligned;
        out_of_range = ack & r_out_of_range;
        rdata        = '0;
        if (ack && !r_wr && !r_misaligned && !r_out_of_range) begin
            rdata = w_ram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) against a word-array reference model.
module tb_mem_responder;

    localparam int DEPTH = 64;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        mis;
        logic        oor;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic [1:0]  req_v = '0;
    logic [1:0]  wr_v = '0;
    logic [31:0] addr_v [2];
    logic [31:0] wdata_v [2];
    logic [1:0]  ack_v;
    logic [1:0]  mis_v;
    logic [1:0]  oor_v;
    logic [1:0]  busy_v;
    logic [31:0] rdata_v [2];

    logic [31:0] mdl [2][DEPTH];
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
        .clock(clk), .reset(rst), .req(req_v[0]), .wr(wr_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .ack(ack_v[0]), .rdata(rdata_v[0]), .misaligned(mis_v[0]),
        .out_of_range(oor_v[0]), .busy(busy_v[0])
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
        .clock(clk), .reset(rst), .req(req_v[1]), .wr(wr_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .ack(ack_v[1]), .rdata(rdata_v[1]), .misaligned(mis_v[1]),
        .out_of_range(oor_v[1]), .busy(busy_v[1])
    );

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", nm, u, act, exp, $time);
        end
    endtask

    function automatic int lat(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(input int u);
        return (u == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int u);
        if (u == 0) q0.delete(0);
        else        q1.delete(0);
    endtask

    task automatic qpush(input int u, input exp_t e);
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Reference behaviour: errors answer on the next cycle with no access; otherwise
    // the access lands WAIT_CYCLES later and reads see the latest write.
    task automatic expect_for(input int u, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input int s);
        exp_t        e;
        logic [29:0] word;
        word    = a[31:2];
        e.mis   = (a[1:0] != 2'b00);
        e.oor   = (word >= 30'(DEPTH));
        e.rdata = '0;
        if (e.mis || e.oor) begin
            e.cyc = s;
        end else begin
            e.cyc = s + lat(u);
            if (w) mdl[u][word[5:0]] = d;
            else   e.rdata = mdl[u][word[5:0]];
        end
        qpush(u, e);
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with it idle again.
    task automatic issue(input int u, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit scramble);
        bit done;
        req_v[u]   = 1'b1;
        wr_v[u]    = w;
        addr_v[u]  = a;
        wdata_v[u] = d;
        @(posedge clk);
        #1;
        expect_for(u, w, a, d, cyc);
        req_v[u] = 1'b0;
        chk("busy_after_req", u, 32'(busy_v[u]), 32'd1);
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy_v[u]) begin
                done = 1'b1;
                break;
            end
            if (scramble) begin
                wr_v[u]    = 1'($urandom);
                addr_v[u]  = $urandom;
                wdata_v[u] = $urandom;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout dut%0d actual=busy expected=idle t=%0t", u, $time);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int          sel;
        a   = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
        sel = $urandom_range(0, 9);
        if (sel == 0) a[1:0] = 2'($urandom_range(1, 3));
        else if (sel == 1) a = $urandom;
        else if (sel == 2) a = 32'h100 + 32'($urandom_range(0, 63));
        return a;
    endfunction

    // Monitor: pops one expectation per ack and checks quiet outputs otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int u = 0; u < 2; u++) begin
                if (ack_v[u]) begin
                    if (qsize(u) == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL ack_unexpected dut%0d actual=1 expected=0 cyc=%0d", u, cyc);
                    end else begin
                        e = qfront(u);
                        qpop(u);
                        chk("ack_cycle", u, 32'(cyc), 32'(e.cyc));
                        chk("rdata", u, rdata_v[u], e.rdata);
                        chk("misaligned", u, 32'(mis_v[u]), 32'(e.mis));
                        chk("out_of_range", u, 32'(oor_v[u]), 32'(e.oor));
                    end
                end else begin
                    chk("quiet_outputs", u, rdata_v[u] | 32'(mis_v[u]) | 32'(oor_v[u]), 32'd0);
                    if (qsize(u) > 0) begin
                        e = qfront(u);
                        if (e.cyc < cyc) begin
                            qpop(u);
                            tests++;
                            fails++;
                            $display("FAIL ack_missing dut%0d actual=none expected_cyc=%0d", u, e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int          s;
        exp_t        e;
        logic [31:0] a;
        int          u;

        addr_v[0] = '0; addr_v[1] = '0;
        wdata_v[0] = '0; wdata_v[1] = '0;

        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ack", k, 32'(ack_v[k]), 32'd0);
            chk("rst_busy", k, 32'(busy_v[k]), 32'd0);
            chk("rst_rdata", k, rdata_v[k], 32'd0);
            chk("rst_flags", k, 32'({mis_v[k], oor_v[k]}), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First request right after reset release; fill both arrays with known words.
        for (int k = 0; k < DEPTH; k++) issue(0, 1'b1, 32'(k * 4), $urandom, 1'b0);
        for (int k = 0; k < DEPTH; k++) issue(1, 1'b1, 32'(k * 4), $urandom, 1'b0);

        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(0, 1'b1, 32'h13, 32'hCAFEF00D, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(0, 1'b0, 32'h100, 32'h0, 1'b0);
        issue(0, 1'b0, 32'h101, 32'h0, 1'b0);

        // Reset while the write is still waiting: it must vanish without ack or update.
        req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'h12345678;
        @(posedge clk);
        #1;
        req_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("abort_ack", 0, 32'(ack_v[0]), 32'd0);
        @(negedge clk);
        chk("abort_ack_late", 0, 32'(ack_v[0]), 32'd0);
        rst = 1'b0;
        issue(0, 1'b0, 32'h20, 32'h0, 1'b0);

        // Zero-wait responder with req held: one access every two cycles.
        req_v[1] = 1'b1; wr_v[1] = 1'b0; addr_v[1] = 32'h0;
        @(posedge clk);
        #1;
        s = cyc;
        for (int k = 0; k < 4; k++) begin
            e.cyc = s + 2 * k; e.rdata = mdl[1][0]; e.mis = 1'b0; e.oor = 1'b0;
            q1.push_back(e);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("busy_toggle", 1, 32'(busy_v[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        req_v[1] = 1'b0;

        for (int n = 0; n < 300; n++) begin
            u = $urandom_range(0, 1);
            a = rand_addr();
            issue(u, 1'($urandom), a, $urandom, 1'b1);
        end

        repeat (5) @(negedge clk);
        chk("drain_q0", 0, 32'(q0.size()), 32'd0);
        chk("drain_q1", 1, 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
